distortion_pipelined: RTL and testbench

Multichannel, parametrised distortion stage with a registered, stallable valid/ready pipeline. It sits between the audio codec receive path and the downstream effects chain. It adds per-sample parameter capture, fractional gain, full-wave and asymmetric modes, saturation and clip flags. One sample frame (all channels) moves per handshake.

---
 rtl/distortion_pipelined.sv | 184 ++++++++++++++++++
 tb/tb_distortion_pipelined.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/distortion_pipelined.sv
// rtl/distortion_pipelined.sv - multichannel distortion stage with a 3-deep stallable valid/ready pipeline
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   in_valid/in_ready  input frame handshake
//   sample_in          CHANNELS signed samples, channel 0 in the lowest bits
//   mode, gain,        per-frame shaping parameters, captured with the frame
//   threshold
//   out_valid/out_ready output frame handshake
//   sample_out         processed frame
//   clip_flag          per-channel threshold-clip or saturation indicator
module distortion_pipelined #(
    parameter int SAMPLE_W  = 16,
    parameter int CHANNELS  = 2,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
    input  logic [2:0]                   mode,
    input  logic [GAIN_W-1:0]            gain,
    input  logic [SAMPLE_W-2:0]          threshold,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*SAMPLE_W-1:0] sample_out,
    output logic [CHANNELS-1:0]          clip_flag
);

    localparam int FW = CHANNELS * SAMPLE_W;
    // Product width: signed sample times non-negative gain, plus one sign bit.
    localparam int PW = SAMPLE_W + GAIN_W + 1;

    localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [PW-1:0]       P_MAX = {{(GAIN_W+1){1'b0}}, S_MAX};
    localparam logic signed [PW-1:0]       P_MIN = {{(GAIN_W+1){1'b1}}, S_MIN};

    logic advance;

    // Stage 1: captured frame and parameters
    logic                s1_valid;
    logic [FW-1:0]       s1_sample;
    logic [2:0]          s1_mode;
    logic [GAIN_W-1:0]   s1_gain;
    logic [SAMPLE_W-2:0] s1_thr;

    // Stage 2: pre-shaped samples
    logic                s2_valid;
    logic [FW-1:0]       s2_y;
    logic [CHANNELS-1:0] s2_clip;
    logic [2:0]          s2_mode;
    logic [GAIN_W-1:0]   s2_gain;

    logic [FW-1:0]       pre_y;
    logic [CHANNELS-1:0] pre_clip;
    logic [FW-1:0]       post_y;
    logic [CHANNELS-1:0] post_clip;
    logic                s2_gain_mode;

    assign advance      = ~out_valid | out_ready;
    assign in_ready     = advance & ~reset;
    assign s2_gain_mode = (s2_mode >= 3'd1) && (s2_mode <= 3'd4);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Pre-shape: one extra bit so -T and the compares never overflow.
        logic signed [SAMPLE_W-1:0] x;
        logic signed [SAMPLE_W:0]   xe;
        logic signed [SAMPLE_W:0]   t_hi;
        logic signed [SAMPLE_W:0]   t_lo;
        logic signed [SAMPLE_W-1:0] y;
        logic                       clip;

        assign x    = s1_sample[c*SAMPLE_W +: SAMPLE_W];
        assign xe   = {x[SAMPLE_W-1], x};
        assign t_hi = {2'b00, s1_thr};
        // Asymmetric mode clips the negative half at half the threshold.
        assign t_lo = (s1_mode == 3'd4) ? -(t_hi >>> 1) : -t_hi;

        always_comb begin
            y    = x;
            clip = 1'b0;
            case (s1_mode)
                3'd1, 3'd4: begin
                    if (xe > t_hi) begin
                        y    = t_hi[SAMPLE_W-1:0];
                        clip = 1'b1;
                    end else if (xe < t_lo) begin
                        y    = t_lo[SAMPLE_W-1:0];
                        clip = 1'b1;
                    end
                end
                3'd2: begin
                    if (x[SAMPLE_W-1]) y = '0;
                end
                3'd3: begin
                    // The most negative sample has no positive counterpart.
                    if (x == S_MIN) begin
                        y    = S_MAX;
                        clip = 1'b1;
                    end else if (x[SAMPLE_W-1]) begin
                        y = -x;
                    end
                end
                default: ;
            endcase
        end

        assign pre_y[c*SAMPLE_W +: SAMPLE_W] = y;
        assign pre_clip[c]                   = clip;

        // Gain: full-precision multiply, floor shift, saturate.
        logic signed [SAMPLE_W-1:0] y2;
        logic signed [PW-1:0]       ye;
        logic signed [PW-1:0]       ge;
        logic signed [PW-1:0]       prod;
        logic signed [PW-1:0]       shifted;
        logic signed [SAMPLE_W-1:0] q;
        logic                       sat;

        assign y2      = s2_y[c*SAMPLE_W +: SAMPLE_W];
        assign ye      = {{(GAIN_W+1){y2[SAMPLE_W-1]}}, y2};
        assign ge      = {{(SAMPLE_W+1){1'b0}}, s2_gain};
        assign prod    = ye * ge;
        assign shifted = prod >>> GAIN_FRAC;

        always_comb begin
            q   = y2;
            sat = 1'b0;
            if (s2_gain_mode) begin
                if (shifted > P_MAX) begin
                    q   = S_MAX;
                    sat = 1'b1;
                end else if (shifted < P_MIN) begin
                    q   = S_MIN;
                    sat = 1'b1;
                end else begin
                    q = shifted[SAMPLE_W-1:0];
                end
            end
        end

        assign post_y[c*SAMPLE_W +: SAMPLE_W] = q;
        assign post_clip[c]                   = s2_gain_mode & (sat | s2_clip[c]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_sample  <= '0;
            s1_mode    <= '0;
            s1_gain    <= '0;
            s1_thr     <= '0;
            s2_valid   <= 1'b0;
            s2_y       <= '0;
            s2_clip    <= '0;
            s2_mode    <= '0;
            s2_gain    <= '0;
            out_valid  <= 1'b0;
            sample_out <= '0;
            clip_flag  <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid & in_ready;
            s1_sample <= sample_in;
            s1_mode   <= mode;
            s1_gain   <= gain;
            s1_thr    <= threshold;
            s2_valid  <= s1_valid;
            s2_y      <= pre_y;
            s2_clip   <= pre_clip;
            s2_mode   <= s1_mode;
            s2_gain   <= s1_gain;
            out_valid <= s2_valid;
            // Bubbles leave the last emitted frame on the outputs.
            if (s2_valid) begin
                sample_out <= post_y;
                clip_flag  <= post_clip;
            end
        end
    end

endmodule

// File: tb/tb_distortion_pipelined.sv
// tb/tb_distortion_pipelined.sv - randomized and directed self-checking bench for distortion_pipelined
module tb_distortion_pipelined;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sample_in;
    logic [2:0]  mode;
    logic [7:0]  gain;
    logic [14:0] threshold;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sample_out;
    logic [1:0]  clip_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  c;
    } exp_t;

    int f_x0[64];
    int f_x1[64];
    int f_m[64];
    int f_g[64];
    int f_t[64];

    distortion_pipelined #(
        .SAMPLE_W(16), .CHANNELS(2), .GAIN_W(8), .GAIN_FRAC(4)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sample_in(sample_in), .mode(mode), .gain(gain), .threshold(threshold),
        .out_valid(out_valid), .out_ready(out_ready), .sample_out(sample_out),
        .clip_flag(clip_flag)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on one channel.
    function automatic void model_ch(input int x, input int m, input int g, input int t,
                                     output int y, output bit c);
        int p;
        y = x;
        c = 1'b0;
        if (m >= 1 && m <= 4) begin
            if (m == 1 || m == 4) begin
                int lo;
                lo = (m == 4) ? -(t / 2) : -t;
                if (x > t) begin y = t; c = 1'b1; end
                else if (x < lo) begin y = lo; c = 1'b1; end
            end else if (m == 2) begin
                if (x < 0) y = 0;
            end else begin
                y = (x < 0) ? -x : x;
                if (y > 32767) begin y = 32767; c = 1'b1; end
            end
            p = y * g;
            y = (p >= 0) ? p / 16 : -((-p + 15) / 16);
            if (y > 32767) begin y = 32767; c = 1'b1; end
            else if (y < -32768) begin y = -32768; c = 1'b1; end
        end
    endfunction

    function automatic exp_t model_frame(input int x0, input int x1, input int m,
                                         input int g, input int t);
        exp_t e;
        int   y0, y1;
        bit   c0, c1;
        model_ch(x0, m, g, t, y0, c0);
        model_ch(x1, m, g, t, y1, c1);
        e.d = {16'(y1), 16'(y0)};
        e.c = {c1, c0};
        return e;
    endfunction

    function automatic int rand_sample();
        logic [15:0] b;
        int r;
        r = $urandom % 8;
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        b = 16'($urandom);
        return int'($signed(b));
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sample_in = '0;
        mode      = '0;
        gain      = '0;
        threshold = '0;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sample_out !== 32'h0 || clip_flag !== 2'b00)
            begin bad++; $display("FAIL reset_outputs: got v=%b d=%h c=%b want 0", out_valid, sample_out, clip_flag); end
        total++;
        if (in_ready !== 1'b0)
            begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1)
            begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic send_one(input string nm, input int x0, input int x1, input int m,
                            input int g, input int t, input int e0, input int e1,
                            input logic [1:0] ec);
        int          lat;
        logic [31:0] ef;
        @(negedge clk);
        sample_in = {16'(x1), 16'(x0)};
        mode      = 3'(m);
        gain      = 8'(g);
        threshold = 15'(t);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                // Parameters on the bus after acceptance must not affect this frame.
                in_valid  = 1'b0;
                mode      = 3'($urandom);
                gain      = 8'($urandom);
                threshold = 15'($urandom);
                sample_in = $urandom;
            end
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        ef = {16'(e1), 16'(e0)};
        total++;
        if (lat !== 3)
            begin bad++; $display("FAIL %s latency: got %0d want 3", nm, lat); end
        total++;
        if (sample_out !== ef)
            begin bad++; $display("FAIL %s data: got %h want %h", nm, sample_out, ef); end
        total++;
        if (clip_flag !== ec)
            begin bad++; $display("FAIL %s clip: got %b want %b", nm, clip_flag, ec); end
    endtask

    task automatic test_directed();
        send_one("bypass",     -1234,  5000, 0, 32,  0,     -1234,  5000, 2'b00);
        send_one("hard_clip",  12000, -9000, 1, 16,  8000,   8000, -8000, 2'b11);
        send_one("clip_gain5", 1000,   0,    1, 80,  8000,   5000,  0,    2'b00);
        send_one("clip_sat",   8000,   0,    1, 80,  8000,   32767, 0,    2'b01);
        send_one("half_wave",  -300,   300,  2, 16,  0,      0,     300,  2'b00);
        send_one("full_wave",  -300,   0,    3, 16,  0,      300,   0,    2'b00);
        send_one("full_min",   -32768, 0,    3, 16,  0,      32767, 0,    2'b01);
        send_one("asym",       -900,   0,    4, 16,  1000,  -500,   0,    2'b01);
        send_one("frac",       -3,     3,    1, 24,  32767, -5,     4,    2'b00);
        send_one("gain_zero",  5000,  -5000, 1, 0,   8000,   0,     0,    2'b00);
        send_one("thr_zero",   7,     -7,    1, 16,  0,      0,     0,    2'b11);
        send_one("bypass6",    100,   -100,  6, 200, 0,      100,  -100,  2'b00);
    endtask

    // rdy_mode 0: random out_ready; 1: repeating 1,0,0 pattern.
    task automatic run_stream(input string nm, input int n, input int rdy_mode, input bit gaps);
        exp_t        q[$];
        exp_t        e;
        int          idx = 0;
        int          got = 0;
        int          cyc = 0;
        bit          held = 1'b0;
        logic [31:0] hd;
        logic [1:0]  hc;
        while ((idx < n || q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || sample_out !== hd || clip_flag !== hc)
                    begin bad++; $display("FAIL %s stall_hold: got v=%b d=%h c=%b want v=1 d=%h c=%b", nm, out_valid, sample_out, clip_flag, hd, hc); end
            end
            out_ready = (rdy_mode == 1) ? (cyc % 3 == 1) : ($urandom % 3 != 0);
            in_valid  = (idx < n) && (!gaps || ($urandom % 4 != 0));
            if (idx < n) begin
                sample_in = {16'(f_x1[idx]), 16'(f_x0[idx])};
                mode      = 3'(f_m[idx]);
                gain      = 8'(f_g[idx]);
                threshold = 15'(f_t[idx]);
            end
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s extra_frame: got %h want none", nm, sample_out);
                end else begin
                    e = q.pop_front();
                    total++;
                    if (sample_out !== e.d)
                        begin bad++; $display("FAIL %s data[%0d]: got %h want %h", nm, got, sample_out, e.d); end
                    total++;
                    if (clip_flag !== e.c)
                        begin bad++; $display("FAIL %s clip[%0d]: got %b want %b", nm, got, clip_flag, e.c); end
                end
                got++;
            end
            held = out_valid && !out_ready;
            hd   = sample_out;
            hc   = clip_flag;
            if (in_valid && in_ready) begin
                q.push_back(model_frame(f_x0[idx], f_x1[idx], f_m[idx], f_g[idx], f_t[idx]));
                idx++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got !== n || idx !== n)
            begin bad++; $display("FAIL %s count: got %0d out of %0d sent want %0d", nm, got, idx, n); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            f_x0[i] = rand_sample();
            f_x1[i] = rand_sample();
            f_m[i]  = (i < 5) ? 1 : 3;
            f_g[i]  = 16;
            f_t[i]  = 20000;
        end
        run_stream("mode_switch", 10, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            f_x0[i] = rand_sample();
            f_x1[i] = rand_sample();
            f_m[i]  = int'($urandom % 8);
            f_g[i]  = int'($urandom % 256);
            f_t[i]  = int'($urandom % 32768);
        end
        run_stream("random", 60, 0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_in = {16'(i + 1), 16'(100 * (i + 1))};
            mode      = 3'd0;
            in_valid  = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sample_out !== 32'h0 || clip_flag !== 2'b00)
            begin bad++; $display("FAIL mid_reset_outputs: got v=%b d=%h c=%b want 0", out_valid, sample_out, clip_flag); end
        total++;
        if (in_ready !== 1'b0)
            begin bad++; $display("FAIL mid_reset_in_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0)
                begin bad++; $display("FAIL mid_reset_no_pulse: got %b want 0", out_valid); end
        end
        send_one("after_reset", 4321, -4321, 0, 16, 0, 4321, -4321, 2'b00);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
